tff_bank_counter: RTL and testbench
===================================

# tff_bank_counter

Parametrised successor to the single toggle flip-flop: a WIDTH-bit bank of toggle cells that also runs as an up/down counter with load, synchronous clear, wrap or saturate limiting, a terminal-count pulse and a sticky overflow flag. It sits wherever the design needs either per-bit toggle storage or a small event counter. All outputs are registered. Q and Qbar are always complementary, including out of reset.

## Interface
- WIDTH, 8: number of toggle cells / counter bits (≥2).
- RESET_VAL, 0: value of q after async reset and after sync clear.
- SATURATE, 0: 0 means UP/DOWN wrap modulo 2^WIDTH; 1 means they stick at the limit.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  enables the mode operation this cycle.
- clr  in  1  synchronous clear to RESET_VAL; overrides en.
- mode  in  2  operation: 00 TOGGLE, 01 UP, 10 DOWN, 11 LOAD.
- t_in  in  WIDTH  per-bit toggle enables; used in TOGGLE only.
- load_val  in  WIDTH  value loaded in LOAD mode.
- ovf_clr  in  1  clears the sticky ovf flag.
- q  out  WIDTH  cell state.
- qbar  out  WIDTH  registered complement of q.
- tc  out  1  terminal-count pulse, one cycle.
- ovf  out  1  sticky overflow/saturation flag.

## Operation
- Async reset (rst_n=0): q=RESET_VAL, qbar=~RESET_VAL, tc=0, ovf=0, held until rst_n rises. Reset asserted mid-count discards the count immediately.
- Priority each edge: clr, then en. If clr=1: q←RESET_VAL, tc←0. ovf is unaffected by clr.
- If en=0 and clr=0: q holds and tc←0.
- TOGGLE: q←q^t_in. tc←0. Never sets ovf.
- UP: q←q+1 (WIDTH-bit arithmetic). At q=all-ones:
  - SATURATE=0: q wraps to 0, tc←1, ovf←1.
  - SATURATE=1: q stays all-ones, tc←1, ovf←1. This repeats on every blocked increment.
- DOWN: q←q−1. At q=0:
  - SATURATE=0: q wraps to all-ones, tc←1, ovf←1.
  - SATURATE=1: q stays 0, tc←1, ovf←1.
- LOAD: q←load_val. tc←0. No ovf change.
- qbar is updated in the same edge as q with the complement of the next q. It is never derived combinationally.
- ovf_clr clears ovf on the edge. If ovf_clr coincides with a set event, the set wins and ovf stays 1.
- mode is sampled only when en=1. Mode may change every cycle without any settling requirement.

## Timing
- Latency is 1 cycle for every operation: inputs sampled on edge k appear on q, qbar, tc and ovf after edge k.
- tc is high for exactly the cycle following the edge that wrapped or saturated. Back-to-back wrap or saturate events give tc high continuously.
- No handshake: en is a qualifier, not a request. Nothing stalls.
- Reset release is synchronous to the first clk edge with rst_n=1. On that edge the block operates normally.
- Reset path is async on all flops. No combinational path exists from any input to any output.

## Test plan
- Reset/complement, WIDTH=4, RESET_VAL=4'h5: assert rst_n=0 mid-count at q=4'hA -> q=4'h5 and qbar=4'hA immediately, tc=0, ovf=0. Check q==~qbar on every cycle of the run.
- TOGGLE, q=4'b0000: t_in=4'b1010 over 3 enabled edges -> q=1010, 0000, 1010. Holding en=0 keeps q=1010. tc and ovf stay 0.
- UP wrap, SATURATE=0: load 4'hE, then UP ×3 -> q=F, 0, 1. tc high only after the F→0 edge. ovf set and stays set. ovf_clr then gives ovf=0 next cycle.
- Saturate, SATURATE=1: load 4'h1, then DOWN ×3 -> q=0, 0, 0. tc=0, then 1, then 1. ovf=1.
- Priority and collisions:
  - clr=1 with en=1, mode=LOAD, load_val=4'h9 -> q=RESET_VAL.
  - ovf_clr=1 on the same edge as a wrap -> ovf remains 1.
- Mode switching, every cycle with en=1: UP, DOWN, LOAD 4'h7, TOGGLE t_in=4'hF starting from q=4'h3 -> q=4, 3, 7, 8.

Source files
------------

// File: rtl/tff_bank_counter.sv
// Bank of WIDTH toggle cells that doubles as an up/down counter with load,
// synchronous clear, wrap/saturate limiting, terminal-count pulse and sticky overflow.
module tff_bank_counter #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t_in,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             ovf
);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             ovf_set;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        q_next  = q;
        tc_next = 1'b0;
        ovf_set = 1'b0;
        if (clr) begin
            q_next = RESET_VAL;
        end else if (en) begin
            case (mode)
                MODE_TOGGLE: q_next = q ^ t_in;
                MODE_UP: begin
                    if (q == ALL_ONES) begin
                        tc_next = 1'b1;
                        ovf_set = 1'b1;
                        q_next  = SATURATE ? ALL_ONES : ZERO;
                    end else begin
                        q_next = q + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (q == ZERO) begin
                        tc_next = 1'b1;
                        ovf_set = 1'b1;
                        q_next  = SATURATE ? ZERO : ALL_ONES;
                    end else begin
                        q_next = q - ONE;
                    end
                end
                MODE_LOAD: q_next = load_val;
                default:   q_next = q;
            endcase
        end
    end

    // qbar is its own register loaded with the complement of the next q, so
    // q and qbar stay complementary without a combinational inverter on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            q    <= RESET_VAL;
            qbar <= ~RESET_VAL;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            q    <= q_next;
            qbar <= ~q_next;
            tc   <= tc_next;
            // A set event on the same edge as ovf_clr wins.
            ovf  <= ovf_set | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_tff_bank_counter.sv
// Self-checking bench: a wrapping and a saturating instance driven in parallel,
// compared against an integer-arithmetic reference model.
module tb_tff_bank_counter;

    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'h5;

    localparam logic [1:0] M_TOG  = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n, en, clr, ovf_clr;
    logic [1:0]   mode;
    logic [W-1:0] t_in, load_val;
    logic [W-1:0] q_w, qbar_w, q_s, qbar_s;
    logic         tc_w, ovf_w, tc_s, ovf_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: index 0 = wrapping instance, index 1 = saturating instance.
    int m_q   [2];
    bit m_tc  [2];
    bit m_ovf [2];

    always #5 clk = ~clk;

    tff_bank_counter #(.WIDTH(W), .RESET_VAL(RV), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .t_in(t_in),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(q_w), .qbar(qbar_w), .tc(tc_w), .ovf(ovf_w)
    );

    tff_bank_counter #(.WIDTH(W), .RESET_VAL(RV), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .t_in(t_in),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(q_s), .qbar(qbar_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i]   = int'(RV);
            m_tc[i]  = 1'b0;
            m_ovf[i] = 1'b0;
        end
    endtask

    // One rising edge of the reference, evaluated from the rules with plain integers.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit sat;
            bit evt;
            int nxt;
            sat = (i == 1);
            evt = 1'b0;
            nxt = m_q[i];
            if (clr) begin
                nxt = int'(RV);
            end else if (en) begin
                if (mode == M_TOG) begin
                    nxt = m_q[i] ^ int'(t_in);
                end else if (mode == M_UP) begin
                    nxt = m_q[i] + 1;
                    if (nxt > 15) begin
                        evt = 1'b1;
                        nxt = sat ? 15 : nxt % 16;
                    end
                end else if (mode == M_DOWN) begin
                    nxt = m_q[i] - 1;
                    if (nxt < 0) begin
                        evt = 1'b1;
                        nxt = sat ? 0 : nxt + 16;
                    end
                end else begin
                    nxt = int'(load_val);
                end
            end
            m_q[i]  = nxt;
            m_tc[i] = evt;
            if (evt)          m_ovf[i] = 1'b1;
            else if (ovf_clr) m_ovf[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] ew, es;
        ew = 4'(m_q[0]);
        es = 4'(m_q[1]);
        chk({tag, "/wrap_q"},    q_w,             ew);
        chk({tag, "/wrap_qbar"}, qbar_w,          ~ew);
        chk({tag, "/wrap_tc"},   {3'b000, tc_w},  {3'b000, m_tc[0]});
        chk({tag, "/wrap_ovf"},  {3'b000, ovf_w}, {3'b000, m_ovf[0]});
        chk({tag, "/sat_q"},     q_s,             es);
        chk({tag, "/sat_qbar"},  qbar_s,          ~es);
        chk({tag, "/sat_tc"},    {3'b000, tc_s},  {3'b000, m_tc[1]});
        chk({tag, "/sat_ovf"},   {3'b000, ovf_s}, {3'b000, m_ovf[1]});
    endtask

    // Drive inputs, take one edge, advance the model, sample 1 time unit later.
    task automatic step(input logic e, input logic c, input logic [1:0] m,
                        input logic [3:0] t, input logic [3:0] lv, input logic oc,
                        input string tag);
        en = e; clr = c; mode = m; t_in = t; load_val = lv; ovf_clr = oc;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = M_TOG;
        t_in = '0; load_val = '0; ovf_clr = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset_q_const", q_w, 4'h5);
        chk("reset_qbar_const", qbar_w, 4'hA);
        @(negedge clk);
        rst_n = 1'b1;

        // Toggle from zero.
        step(1, 0, M_LOAD, 4'h0, 4'h0, 0, "load0");
        step(1, 0, M_TOG, 4'b1010, 4'h0, 0, "tog1");
        chk("tog1_q_const", q_w, 4'hA);
        step(1, 0, M_TOG, 4'b1010, 4'h0, 0, "tog2");
        chk("tog2_q_const", q_w, 4'h0);
        step(1, 0, M_TOG, 4'b1010, 4'h0, 0, "tog3");
        step(0, 0, M_TOG, 4'b1010, 4'h0, 0, "hold1");
        step(0, 0, M_UP, 4'b1111, 4'h0, 0, "hold2");
        chk("hold_q_const", q_w, 4'hA);

        // Up wrap / saturate, then ovf_clr.
        step(1, 0, M_LOAD, 4'h0, 4'hE, 0, "loadE");
        step(1, 0, M_UP, 4'h0, 4'h0, 0, "up1");
        step(1, 0, M_UP, 4'h0, 4'h0, 0, "up2");
        chk("up2_wrap_q_const", q_w, 4'h0);
        chk("up2_wrap_tc_const", {3'b000, tc_w}, 4'h1);
        step(1, 0, M_UP, 4'h0, 4'h0, 0, "up3");
        chk("up3_wrap_q_const", q_w, 4'h1);
        chk("up3_sat_tc_const", {3'b000, tc_s}, 4'h1);
        step(0, 0, M_UP, 4'h0, 4'h0, 1, "ovfclr");
        chk("ovfclr_const", {3'b000, ovf_w}, 4'h0);

        // Down toward zero.
        step(1, 0, M_LOAD, 4'h0, 4'h1, 0, "load1");
        step(1, 0, M_DOWN, 4'h0, 4'h0, 0, "dn1");
        step(1, 0, M_DOWN, 4'h0, 4'h0, 0, "dn2");
        step(1, 0, M_DOWN, 4'h0, 4'h0, 0, "dn3");
        chk("dn3_sat_q_const", q_s, 4'h0);
        chk("dn3_wrap_q_const", q_w, 4'hE);

        // clr beats en/LOAD; ovf_clr loses to a coincident wrap.
        step(1, 1, M_LOAD, 4'h0, 4'h9, 0, "clr_vs_load");
        chk("clr_q_const", q_w, 4'h5);
        step(0, 0, M_TOG, 4'h0, 4'h0, 1, "ovfclr2");
        step(1, 0, M_LOAD, 4'h0, 4'hF, 0, "loadF");
        step(1, 0, M_UP, 4'h0, 4'h0, 1, "wrap_vs_ovfclr");
        chk("wrap_vs_ovfclr_const", {3'b000, ovf_w}, 4'h1);

        // Mode change every cycle.
        step(1, 0, M_LOAD, 4'h0, 4'h3, 0, "load3");
        step(1, 0, M_UP, 4'h0, 4'h0, 0, "mix_up");
        chk("mix_up_const", q_w, 4'h4);
        step(1, 0, M_DOWN, 4'h0, 4'h0, 0, "mix_dn");
        chk("mix_dn_const", q_w, 4'h3);
        step(1, 0, M_LOAD, 4'h0, 4'h7, 0, "mix_ld");
        chk("mix_ld_const", q_w, 4'h7);
        step(1, 0, M_TOG, 4'hF, 4'h0, 0, "mix_tog");
        chk("mix_tog_const", q_w, 4'h8);

        // Mid-count async reset with ovf set: takes effect without a clock edge.
        step(1, 0, M_LOAD, 4'h0, 4'hA, 0, "loadA");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_qbar_const", qbar_w, 4'hA);
        en = 1'b1; mode = M_UP;
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst_n = 1'b1;
        step(1, 0, M_UP, 4'h0, 4'h0, 0, "rst_release");

        // Randomized phase against the reference model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 2'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 7) == 0,
                 $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
